if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries (a power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning the fetch stage presents an instruction this cycle.
REQ-005 The block SHALL have port in_pc, input, 32 bits, meaning the PC+4 value of the presented instruction.
REQ-006 The block SHALL have port in_instr, input, 32 bits, meaning the presented instruction word.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the queue accepts a push; the fetch stage freezes when this is low.
REQ-008 The block SHALL have port flush, input, 1 bit, meaning branch taken; discard all queued instructions.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning the head entry is valid for decode.
REQ-010 The block SHALL have port out_pc, output, 32 bits, meaning the head entry PC.
REQ-011 The block SHALL have port out_instr, output, 32 bits, meaning the head entry instruction.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning decode consumes the head this cycle (low when decode is frozen).
REQ-013 The block SHALL have port count, output, log2(DEPTH)+1 bits, meaning current occupancy 0..DEPTH.

Function
REQ-014 Push SHALL occur when in_valid and in_ready and not flush; the entry is written at wr_ptr and wr_ptr advances by 1 modulo DEPTH.
REQ-015 Pop SHALL occur when out_valid and out_ready and not flush; rd_ptr advances by 1 modulo DEPTH.
REQ-016 in_ready SHALL equal (count != DEPTH), combinationally from registered state only; there is no full-with-pop pass-through.
REQ-017 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL be the entry at rd_ptr, combinational from storage.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 Latency SHALL be one cycle: a pushed entry appears on out_* in the cycle after the push edge.
REQ-020 flush SHALL, at the next edge, set count, wr_ptr and rd_ptr to 0, ignoring any simultaneous push or pop.
REQ-021 Push into an empty queue with out_ready high SHALL NOT bypass; out_valid rises only after the edge.
REQ-022 Pointer wrap SHALL be seamless: DEPTH+k sequential pushes with matching pops preserve order.
REQ-023 in_valid while in_ready is low SHALL be ignored; the fetch stage holds the same instruction.
REQ-024 Storage contents SHALL not be altered by flush; only pointers/count are cleared.

Reset
REQ-025 While rst is high: count=0, wr_ptr=0, rd_ptr=0, all storage entries=0, hence out_valid=0, in_ready=1, out_pc=0, out_instr=0.
REQ-026 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-027 The first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro IF_ID_QUEUE_NOP_MASK_EN SHALL select output masking.
REQ-029 With IF_ID_QUEUE_NOP_MASK_EN defined, out_pc and out_instr SHALL be 32'h0 whenever out_valid is 0.
REQ-030 Without IF_ID_QUEUE_NOP_MASK_EN, out_pc/out_instr SHALL show the storage entry at rd_ptr regardless of out_valid.

Verification
REQ-031 Reset then push pc=4,instr=32'hE3A01005 with out_ready=0 -> next cycle out_valid=1, out_instr=32'hE3A01005, count=1.
REQ-032 out_ready=0, push 4 entries (DEPTH=4) -> count=4, in_ready=0; a fifth in_valid is ignored; then pop 4 -> order preserved, count=0.
REQ-033 count=2 and push+pop same cycle -> count stays 2, head advances to the second entry.
REQ-034 count=3 with flush=1 and in_valid=1 same cycle -> next cycle count=0, out_valid=0, in_ready=1.
REQ-035 Stream 10 entries with out_ready=1 continuously -> pointers wrap, all 10 emerge in order, one cycle after each push.
REQ-036 rst pulsed between edges with count=2 -> out_valid=0 immediately; with IF_ID_QUEUE_NOP_MASK_EN out_instr=0 whenever empty.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of {PC+4, instruction}.
// Optional macro IF_ID_QUEUE_NOP_MASK_EN forces out_pc/out_instr to zero while the queue is empty.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [63:0]   mem_r [DEPTH];
  logic [PW-1:0] wrPtr_r;
  logic [PW-1:0] rdPtr_r;
  logic [CW-1:0] count_r;
  logic          pushEn_s;
  logic          popEn_s;
  logic [63:0]   head_s;

  assign in_ready  = (count_r != CNT_FULL);
  assign out_valid = (count_r != {CW{1'b0}});
  assign count     = count_r;
  assign pushEn_s  = in_valid & in_ready & ~flush;
  assign popEn_s   = out_valid & out_ready & ~flush;
  assign head_s    = mem_r[rdPtr_r];

  // Entry storage: cleared only by reset, written on accepted pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'h0;
      end
    end else if (pushEn_s) begin
      mem_r[wrPtr_r] <= {in_pc, in_instr};
    end
  end

  // Pointer and occupancy tracking; flush discards everything but leaves storage intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_r <= {PW{1'b0}};
      rdPtr_r <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      wrPtr_r <= {PW{1'b0}};
      rdPtr_r <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (pushEn_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (popEn_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      case ({pushEn_s, popEn_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation, optionally masked to a zero bubble when empty.
  always_comb begin
    out_pc    = head_s[63:32];
    out_instr = head_s[31:0];
`ifdef IF_ID_QUEUE_NOP_MASK_EN
    if (out_valid) begin
      out_pc    = head_s[63:32];
      out_instr = head_s[31:0];
    end else begin
      out_pc    = 32'h0;
      out_instr = 32'h0;
    end
`else
    if (out_valid) begin
      out_pc    = head_s[63:32];
      out_instr = head_s[31:0];
    end else begin
      out_pc    = head_s[63:32];
      out_instr = head_s[31:0];
    end
`endif
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized self-checking bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [$clog2(DEPTH):0] count;

  int vecs = 0;
  int errs = 0;
  logic [63:0] q[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
  endtask

  // One clock edge; the model applies the queue rules to the inputs seen before the edge.
  task automatic cycle();
    bit doPush, doPop, doFlush;
    logic [63:0] ent;
    doFlush = flush;
    doPush  = in_valid && (q.size() < DEPTH) && !flush;
    doPop   = (q.size() > 0) && out_ready && !flush;
    ent     = {in_pc, in_instr};
    @(posedge clk);
    #1;
    if (doFlush) q.delete();
    else begin
      if (doPop) void'(q.pop_front());
      if (doPush) q.push_back(ent);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (count !== 0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++;
      $display("FAIL reset_flags got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    vecs++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errs++;
      $display("FAIL reset_data got %h/%h want 0/0", out_pc, out_instr); end
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_single();
    drive(1'b1, 32'd4, 32'hE3A01005, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vecs++; if (out_valid !== 1'b1 || out_instr !== 32'hE3A01005 || out_pc !== 32'd4 || count !== 1) begin
      errs++; $display("FAIL single_push got v=%b pc=%h i=%h c=%0d want 1/4/e3a01005/1",
                       out_valid, out_pc, out_instr, count); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle();
  endtask

  task automatic test_fill();
    logic [63:0] head;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      cycle();
    end
    vecs++; if (count !== DEPTH || in_ready !== 1'b0) begin errs++;
      $display("FAIL fill_full got c=%0d r=%b want %0d/0", count, in_ready, DEPTH); end
    drive(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0);
    cycle();
    vecs++; if (count !== DEPTH || out_instr !== q[0][31:0]) begin errs++;
      $display("FAIL fill_ignored got c=%0d i=%h want %0d/%h", count, out_instr, DEPTH, q[0][31:0]); end
    for (int i = 0; i < DEPTH; i++) begin
      head = q[0];
      vecs++; if ({out_pc, out_instr} !== head || out_valid !== 1'b1) begin errs++;
        $display("FAIL fill_order[%0d] got %h want %h", i, {out_pc, out_instr}, head); end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle();
    end
    vecs++; if (count !== 0 || out_valid !== 1'b0) begin errs++;
      $display("FAIL fill_drained got c=%0d v=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_push_pop();
    logic [63:0] second;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      cycle();
    end
    second = q[1];
    drive(1'b1, $urandom, $urandom, 1'b1, 1'b0);
    cycle();
    vecs++; if (count !== 2 || {out_pc, out_instr} !== second) begin errs++;
      $display("FAIL push_pop got c=%0d head=%h want 2/%h", count, {out_pc, out_instr}, second); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, $urandom, $urandom, 1'b1, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vecs++; if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++;
      $display("FAIL flush got c=%0d v=%b r=%b want 0/0/1", count, out_valid, in_ready); end
  endtask

  task automatic test_stream();
    logic [63:0] sent [10];
    for (int i = 0; i < 10; i++) begin
      sent[i] = {$urandom, $urandom};
      drive(1'b1, sent[i][63:32], sent[i][31:0], 1'b1, 1'b0);
      if (i == 0) begin
        vecs++; if (out_valid !== 1'b0) begin errs++;
          $display("FAIL no_bypass got v=%b want 0", out_valid); end
      end
      cycle();
      vecs++; if (out_valid !== 1'b1 || count !== 1 || {out_pc, out_instr} !== sent[i]) begin errs++;
        $display("FAIL stream[%0d] got v=%b c=%0d %h want 1/1/%h", i, out_valid, count,
                 {out_pc, out_instr}, sent[i]); end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    vecs++; if (count !== 0) begin errs++; $display("FAIL stream_end got c=%0d want 0", count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom | 32'h1, $urandom | 32'h1, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    vecs++; if (out_valid !== 1'b0 || count !== 0 || in_ready !== 1'b1 || out_instr !== 32'h0) begin errs++;
      $display("FAIL async_reset got v=%b c=%0d r=%b i=%h want 0/0/1/0", out_valid, count, in_ready, out_instr); end
    #1 rst = 1'b0;
    q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 30) == 0);
      cycle();
      vecs++; if (count !== q.size() || out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH)) begin
        errs++; $display("FAIL rand_state[%0d] got c=%0d v=%b r=%b want c=%0d", n, count, out_valid,
                         in_ready, q.size()); end
      if (q.size() != 0) begin
        vecs++; if ({out_pc, out_instr} !== q[0]) begin errs++;
          $display("FAIL rand_head[%0d] got %h want %h", n, {out_pc, out_instr}, q[0]); end
      end else begin
`ifdef IF_ID_QUEUE_NOP_MASK_EN
        vecs++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errs++;
          $display("FAIL rand_mask[%0d] got %h/%h want 0/0", n, out_pc, out_instr); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_push_pop();
    test_flush();
    test_stream();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
